// File: rtl/fnd_pkg.sv
`default_nettype none
//==============================================================================
// Package  : fnd_pkg
// Brief    : Shared types and constants for the FND display / button front end.
// Revision : 1.0
//==============================================================================
package fnd_pkg;

    localparam int BTN_W               = 4;
    localparam int CODE_W              = 2;
    // 10 ms at 12 MHz; also used by the stopwatch top
    localparam int DEBOUNCE_CYCLES_DEF = 120000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        WAIT_REL = 2'd2
    } btn_state_t;

    function automatic logic [CODE_W-1:0] prio_enc(input logic [BTN_W-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        casez (v)
            4'b1???: r = 2'd3;
            4'b01??: r = 2'd2;
            4'b001?: r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_debounce.sv
`default_nettype none
//==============================================================================
// Module   : btn_sync_debounce
// Brief    : Two-flop synchroniser plus vector-wide debounce of the button bus.
// Revision : 1.0
//==============================================================================
module btn_sync_debounce
    import fnd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [BTN_W-1:0] i_btn,
    output logic [BTN_W-1:0] o_stable
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [BTN_W-1:0] r_sync1;
    logic [BTN_W-1:0] r_sync2;
    logic [BTN_W-1:0] r_cand;
    logic [BTN_W-1:0] r_stable;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Any change on any bit restarts the window; the counter saturates once stable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand   <= '0;
            r_count  <= '0;
            r_stable <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand  <= r_sync2;
            r_count <= '0;
        end else if (r_count == c_cnt_max) begin
            r_stable <= r_cand;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/button_encoder_4x2.sv
`default_nettype none
//==============================================================================
// Module   : button_encoder_4x2
// Brief    : Debounced 4-button priority encoder with press/release event pulses.
// Revision : 1.0
//==============================================================================
module button_encoder_4x2
    import fnd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [BTN_W-1:0]  i_btn,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    output logic              o_press,
    output logic              o_release
);

    logic [BTN_W-1:0]  w_stable;
    logic [CODE_W-1:0] w_enc;
    logic              w_any;

    btn_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_btn    (i_btn),
        .o_stable (w_stable)
    );

    assign w_enc = prio_enc(w_stable);
    assign w_any = |w_stable;

    btn_state_t        r_state;
    btn_state_t        w_next_state;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_next_code;
    logic              r_valid;
    logic              w_next_valid;
    logic              r_press;
    logic              w_next_press;
    logic              r_release;
    logic              w_next_release;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_code    <= w_next_code;
            r_valid   <= w_next_valid;
            r_press   <= w_next_press;
            r_release <= w_next_release;
        end
    end

    // Disabling parks held buttons in WAIT_REL so re-enabling never fabricates a press.
    always_comb begin
        w_next_state   = r_state;
        w_next_code    = r_code;
        w_next_valid   = r_valid;
        w_next_press   = 1'b0;
        w_next_release = 1'b0;
        if (!i_en) begin
            w_next_state = w_any ? WAIT_REL : IDLE;
            w_next_code  = '0;
            w_next_valid = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_next_state = PRESSED;
                        w_next_code  = w_enc;
                        w_next_valid = 1'b1;
                        w_next_press = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_any) begin
                        w_next_state   = IDLE;
                        w_next_code    = '0;
                        w_next_valid   = 1'b0;
                        w_next_release = 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (!w_any) begin
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_next_code  = '0;
                    w_next_valid = 1'b0;
                end
            endcase
        end
    end

    assign o_code    = r_code;
    assign o_valid   = r_valid;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_button_encoder_4x2.sv
`default_nettype none
//==============================================================================
// Module   : tb_button_encoder_4x2
// Brief    : Randomised and directed bench for button_encoder_4x2 with a reference model.
// Revision : 1.0
//==============================================================================
module tb_button_encoder_4x2;

    localparam int D = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_en;
    logic [3:0] i_btn;
    logic [1:0] o_code;
    logic       o_valid;
    logic       o_press;
    logic       o_release;

    always #5 i_clk = ~i_clk;

    button_encoder_4x2 #(
        .DEBOUNCE_CYCLES (D)
    ) u_dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_btn     (i_btn),
        .o_code    (o_code),
        .o_valid   (o_valid),
        .o_press   (o_press),
        .o_release (o_release)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw sample history, accepted level, and a tiny event machine
    logic [3:0] hist[$];
    logic [3:0] m_stable;
    int         m_mode;     // 0 = idle, 1 = press accepted, 2 = waiting for full release
    logic [1:0] m_code;
    logic       m_valid;
    logic       m_press;
    logic       m_release;

    int edge_no;
    int first_press;
    int first_release;
    int press_seen;
    int release_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int top_index(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < D + 3; i++) hist.push_back(4'b0000);
        m_stable  = 4'b0000;
        m_mode    = 0;
        m_code    = 2'd0;
        m_valid   = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
    endtask

    task automatic clear_counts();
        edge_no       = 0;
        first_press   = 0;
        first_release = 0;
        press_seen    = 0;
        release_seen  = 0;
    endtask

    // One rising edge: events react to the accepted level from before the edge;
    // the accepted level becomes the raw value seen over D+1 consecutive samples
    // taken two edges earlier.
    task automatic model_edge(input logic [3:0] btn, input logic en);
        int  last;
        bit  same;
        m_press   = 1'b0;
        m_release = 1'b0;
        if (!en) begin
            m_mode  = (m_stable != 0) ? 2 : 0;
            m_valid = 1'b0;
            m_code  = 2'd0;
        end else if (m_mode == 0 && m_stable != 0) begin
            m_mode  = 1;
            m_code  = 2'(top_index(m_stable));
            m_valid = 1'b1;
            m_press = 1'b1;
        end else if (m_mode == 1 && m_stable == 0) begin
            m_mode    = 0;
            m_code    = 2'd0;
            m_valid   = 1'b0;
            m_release = 1'b1;
        end else if (m_mode == 2 && m_stable == 0) begin
            m_mode = 0;
        end
        hist.push_back(btn);
        last = hist.size() - 3;
        same = 1'b1;
        for (int k = 1; k <= D; k++) begin
            if (hist[last - k] !== hist[last]) same = 1'b0;
        end
        if (same) m_stable = hist[last];
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic step(input logic [3:0] btn, input logic en);
        i_btn = btn;
        i_en  = en;
        @(posedge i_clk);
        model_edge(btn, en);
        edge_no++;
        #1;
        check("code",    32'(o_code),    32'(m_code));
        check("valid",   32'(o_valid),   32'(m_valid));
        check("press",   32'(o_press),   32'(m_press));
        check("release", 32'(o_release), 32'(m_release));
        check("press_and_release", 32'(o_press & o_release), 32'd0);
        if (o_press === 1'b1) begin
            press_seen++;
            if (first_press == 0) first_press = edge_no;
        end
        if (o_release === 1'b1) begin
            release_seen++;
            if (first_release == 0) first_release = edge_no;
        end
    endtask

    task automatic hold(input logic [3:0] btn, input logic en, input int n);
        for (int i = 0; i < n; i++) step(btn, en);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_code"},    32'(o_code),    32'd0);
        check({tag, "_valid"},   32'(o_valid),   32'd0);
        check({tag, "_press"},   32'(o_press),   32'd0);
        check({tag, "_release"}, 32'(o_release), 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_btn   = 4'b0000;
        #23;
        check_outputs_zero("por");
        i_rst_n = 1'b1;
        model_reset();
        clear_counts();

        // Reset mid-press, then a still-held button is a fresh press
        hold(4'b0100, 1'b1, 12);
        check("pre_reset_valid", 32'(o_valid), 32'd1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(posedge i_clk);
        #3;
        check_outputs_zero("in_rst");
        i_rst_n = 1'b1;
        model_reset();
        clear_counts();
        hold(4'b0100, 1'b1, 10);
        check("rst_press_edge", 32'(first_press), 32'd8);
        check("rst_press_code", 32'(o_code), 32'd2);
        check("rst_no_release", 32'(release_seen), 32'd0);
        hold(4'b0000, 1'b1, 12);

        // Clean press and release
        clear_counts();
        hold(4'b0010, 1'b1, 20);
        check("clean_press_edge", 32'(first_press), 32'd8);
        check("clean_press_cnt", 32'(press_seen), 32'd1);
        check("clean_code_held", 32'(o_code), 32'd1);
        clear_counts();
        hold(4'b0000, 1'b1, 12);
        check("clean_release_edge", 32'(first_release), 32'd8);
        check("clean_release_cnt", 32'(release_seen), 32'd1);

        // Bounce: 2-cycle toggles, then settle high
        clear_counts();
        for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 2);
        hold(4'b0001, 1'b1, 20);
        check("bounce_press_cnt", 32'(press_seen), 32'd1);
        check("bounce_press_edge", 32'(first_press), 32'd20);
        hold(4'b0000, 1'b1, 12);

        // Priority lock while held
        clear_counts();
        hold(4'b0001, 1'b1, 12);
        hold(4'b1001, 1'b1, 12);
        check("hold_code", 32'(o_code), 32'd0);
        hold(4'b1000, 1'b1, 12);
        check("hold_press_cnt", 32'(press_seen), 32'd1);
        check("hold_no_release", 32'(release_seen), 32'd0);
        hold(4'b0000, 1'b1, 12);
        check("hold_release_cnt", 32'(release_seen), 32'd1);

        // Simultaneous buttons
        clear_counts();
        hold(4'b1010, 1'b1, 12);
        check("simul_press_cnt", 32'(press_seen), 32'd1);
        check("simul_code", 32'(o_code), 32'd3);
        hold(4'b0000, 1'b1, 12);

        // Enable gating
        clear_counts();
        hold(4'b0100, 1'b0, 12);
        hold(4'b0100, 1'b1, 12);
        check("en_rise_no_press", 32'(press_seen), 32'd0);
        hold(4'b0000, 1'b1, 12);
        hold(4'b0100, 1'b1, 12);
        check("en_repress_cnt", 32'(press_seen), 32'd1);
        check("en_repress_code", 32'(o_code), 32'd2);
        step(4'b0100, 1'b0);
        check("en_drop_valid", 32'(o_valid), 32'd0);
        hold(4'b0000, 1'b1, 12);
        check("en_drop_no_release", 32'(release_seen), 32'd0);

        // Randomised segments against the model
        for (int s = 0; s < 300; s++) begin
            logic [3:0] b;
            logic       e;
            b = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 9) != 0);
            hold(b, e, $urandom_range(1, 10));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
